accumulator_alu: RTL

- 8-bit accumulator ALU directly downstream of the 4-channel 8-bit operand multiplexer.
- Consumes the selected operand on OPD, combines it with the internal accumulator ACC, and writes the result back with carry/zero flags.
- Single-cycle ops for load/arithmetic/logic/shift; 8x8 multiply runs as a multi-cycle shift-add sequence with a BUSY/DONE handshake toward the control sequencer.

---
 rtl/accumulator_alu.sv | 137 +++++++++++++
 1 files changed

// File: rtl/accumulator_alu.sv
// Purpose: 8-bit accumulator ALU; single-cycle load/arith/logic/shift, 8-cycle shift-add unsigned multiply.
// Latency: single-cycle ops write at the accepting edge (DONE next cycle); MUL writes after 8 MUL_RUN edges.
// Backpressure: START is taken only in IDLE; START during BUSY is dropped, never queued.
module accumulator_alu (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] OPD,
    input  logic [2:0] OP,
    input  logic       START,
    output logic [7:0] ACC,
    output logic [7:0] HI,
    output logic       CF,
    output logic       ZF,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic [15:0] pp;
    logic [15:0] pp_nxt;
    logic        accept;
    logic        last_step;
    logic [7:0]  alu_res;
    logic        alu_cf;

    assign accept    = START && (state == IDLE);
    assign last_step = (state == MUL_RUN) && (cnt == 3'd7);
    assign BUSY      = (state == MUL_RUN);

    // Next-state logic: enter MUL_RUN on an accepted multiply, leave after the 8th step.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && (OP == OP_MUL)) state_nxt = MUL_RUN;
            MUL_RUN: if (cnt == 3'd7)              state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle result and carry for the non-multiply opcodes.
    always_comb begin
        alu_res = ACC;
        alu_cf  = 1'b0;
        case (OP)
            OP_LOAD: alu_res = OPD;
            OP_ADD:  {alu_cf, alu_res} = {1'b0, ACC} + {1'b0, OPD};
            OP_SUB:  begin
                alu_res = ACC - OPD;
                alu_cf  = (ACC < OPD);
            end
            OP_AND:  alu_res = ACC & OPD;
            OP_OR:   alu_res = ACC | OPD;
            OP_XOR:  alu_res = ACC ^ OPD;
            OP_SHL:  begin
                alu_res = {ACC[6:0], 1'b0};
                alu_cf  = ACC[7];
            end
            default: begin
                alu_res = ACC;
                alu_cf  = 1'b0;
            end
        endcase
    end

    // One shift-add step: add the multiplicand shifted to the current multiplier bit position.
    always_comb begin
        pp_nxt = pp;
        if (mplier[cnt]) pp_nxt = pp + ({8'd0, mcand} << cnt);
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // Multiply working registers; loaded on accept, stepped every MUL_RUN cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt    <= 3'd0;
            mcand  <= 8'd0;
            mplier <= 8'd0;
            pp     <= 16'd0;
        end else if (accept && (OP == OP_MUL)) begin
            cnt    <= 3'd0;
            mcand  <= OPD;
            mplier <= ACC;
            pp     <= 16'd0;
        end else if (state == MUL_RUN) begin
            cnt <= cnt + 3'd1;
            pp  <= pp_nxt;
        end
    end

    // Architectural results and flags; they only move when an op completes, so they hold during MUL_RUN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ACC  <= 8'd0;
            HI   <= 8'd0;
            CF   <= 1'b0;
            ZF   <= 1'b0;
            DONE <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (last_step) begin
                {HI, ACC} <= pp_nxt;
                CF        <= (pp_nxt[15:8] != 8'd0);
                ZF        <= (pp_nxt == 16'd0);
                DONE      <= 1'b1;
            end else if (accept && (OP != OP_MUL)) begin
                ACC  <= alu_res;
                CF   <= alu_cf;
                ZF   <= (alu_res == 8'd0);
                DONE <= 1'b1;
            end
        end
    end

endmodule
